// File: rtl/shifter_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : shifter_pipe_if
//  Description : Issue/result handshake bundle for the pipelined barrel shifter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface shifter_pipe_if #(
    parameter int CNT_W = 4,
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [CNT_W-1:0] in_cnt;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;

    modport master (
        output in_valid, in_data, in_cnt, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_zero
    );

    modport slave (
        input  in_valid, in_data, in_cnt, in_op, out_ready,
        output in_ready, out_valid, out_data, out_zero
    );
endinterface
`default_nettype wire

// File: rtl/shifter_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : shifter_pipe
//  Description : log2(WIDTH)-stage registered barrel shifter (ROL/SLL/ROR/SRL)
//                with a global-stall valid/ready pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
module shifter_pipe #(
    parameter int CNT_W = 4,
    parameter int WIDTH = 16
) (
    input  wire logic     clk,
    input  wire logic     rst,
    input  wire logic     flush,
    shifter_pipe_if.slave bus
);
    localparam logic [1:0] c_ROL = 2'b00;
    localparam logic [1:0] c_SLL = 2'b01;
    localparam logic [1:0] c_ROR = 2'b10;

    if (WIDTH != (1 << CNT_W)) begin : g_bad_width
        $error("shifter_pipe: WIDTH must equal 2**CNT_W");
    end

    logic w_adv;
    logic r_zero;

    assign w_adv         = !g_stage[CNT_W-1].r_valid || bus.out_ready;
    assign bus.in_ready  = w_adv;
    assign bus.out_valid = g_stage[CNT_W-1].r_valid;
    assign bus.out_data  = g_stage[CNT_W-1].r_data;
    assign bus.out_zero  = r_zero;

    // Stage k consumes count bit k and forwards only the bits still to be used,
    // so each stage's count register shrinks by one bit.
    for (genvar k = 0; k < CNT_W; k++) begin : g_stage
        localparam int c_SH = 1 << k;

        logic               w_src_valid;
        logic [WIDTH-1:0]   w_src_data;
        logic [1:0]         w_src_op;
        logic [CNT_W-k-1:0] w_src_rem;
        logic [WIDTH-1:0]   w_shifted;
        logic               r_valid;
        logic [WIDTH-1:0]   r_data;

        if (k == 0) begin : g_head
            assign w_src_valid = bus.in_valid;
            assign w_src_data  = bus.in_data;
            assign w_src_op    = bus.in_op;
            assign w_src_rem   = bus.in_cnt;
        end else begin : g_body
            assign w_src_valid = g_stage[k-1].r_valid;
            assign w_src_data  = g_stage[k-1].r_data;
            assign w_src_op    = g_stage[k-1].g_fwd.r_op;
            assign w_src_rem   = g_stage[k-1].g_fwd.r_rem;
        end

        always_comb begin
            w_shifted = w_src_data;
            if (w_src_rem[0]) begin
                case (w_src_op)
                    c_ROL:   w_shifted = (w_src_data << c_SH) | (w_src_data >> (WIDTH - c_SH));
                    c_SLL:   w_shifted = w_src_data << c_SH;
                    c_ROR:   w_shifted = (w_src_data >> c_SH) | (w_src_data << (WIDTH - c_SH));
                    default: w_shifted = w_src_data >> c_SH;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_data  <= '0;
            end else begin
                if (flush) begin
                    r_valid <= 1'b0;
                end else if (w_adv) begin
                    r_valid <= w_src_valid;
                end
                if (w_adv) begin
                    r_data <= w_shifted;
                end
            end
        end

        if (k < CNT_W - 1) begin : g_fwd
            logic [1:0]         r_op;
            logic [CNT_W-k-2:0] r_rem;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_op  <= '0;
                    r_rem <= '0;
                end else if (w_adv) begin
                    r_op  <= w_src_op;
                    r_rem <= w_src_rem[CNT_W-k-1:1];
                end
            end
        end
    end

    // Zero flag is computed from the final stage's next value so it tracks out_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero <= 1'b0;
        end else if (w_adv) begin
            r_zero <= (g_stage[CNT_W-1].w_shifted == '0);
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_shifter_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shifter_pipe
//  Description : Self-checking bench for shifter_pipe (CNT_W=4 directed, 3/4/5 random).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shifter_pipe;
    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic flush = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    shifter_pipe_if #(.CNT_W(4), .WIDTH(16)) dif ();
    shifter_pipe #(.CNT_W(4), .WIDTH(16)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (dif.slave)
    );

    // Reference: bit i of the operand lands at its rotated/shifted position.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int c,
                                              input logic [1:0] op, input int w);
        logic [31:0] r = '0;
        for (int i = 0; i < w; i++) begin
            case (op)
                2'b00:   r[(i + c) % w] = d[i];
                2'b01:   if (i + c < w) r[i + c] = d[i];
                2'b10:   r[(i - c + w) % w] = d[i];
                default: if (i - c >= 0) r[i - c] = d[i];
            endcase
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input logic [15:0] d, input logic [3:0] c, input logic [1:0] op,
                           output logic [15:0] od, output logic oz, output int lat);
        dif.out_ready = 1'b1;
        dif.in_valid  = 1'b1;
        dif.in_data   = d;
        dif.in_cnt    = c;
        dif.in_op     = op;
        lat = 0;
        od  = '0;
        oz  = 1'b0;
        tick();
        dif.in_valid = 1'b0;
        for (int i = 1; i <= 12 && lat == 0; i++) begin
            if (dif.out_valid) begin
                lat = i;
                od  = dif.out_data;
                oz  = dif.out_zero;
            end else begin
                tick();
            end
        end
    endtask

    task automatic check_sweep(input int cw, input bit done,
                               input logic [63:0] e [$], input logic [63:0] g [$]);
        check($sformatf("sweep%0d_done", cw), 64'(done), 64'd1);
        check($sformatf("sweep%0d_count", cw), 64'(g.size()), 64'(e.size()));
        for (int i = 0; i < e.size() && i < g.size(); i++)
            check($sformatf("sweep%0d_op%0d", cw, i), g[i], e[i]);
    endtask

    // Random streams with random back-pressure at CNT_W = 3, 4, 5.
    for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
        localparam int CW = 3 + gi;
        localparam int W  = 1 << CW;

        logic        srst = 1'b1;
        bit          done = 1'b0;
        logic [63:0] exp_q [$];
        logic [63:0] got_q [$];

        shifter_pipe_if #(.CNT_W(CW), .WIDTH(W)) sif ();
        shifter_pipe #(.CNT_W(CW), .WIDTH(W)) u_dut (
            .clk   (clk),
            .rst   (srst),
            .flush (1'b0),
            .bus   (sif.slave)
        );

        initial begin : p_drive
            int          issued;
            logic [31:0] r;
            issued        = 0;
            sif.in_valid  = 1'b0;
            sif.in_data   = '0;
            sif.in_cnt    = '0;
            sif.in_op     = '0;
            sif.out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            srst = 1'b0;
            for (int cyc = 0; cyc < 4000 && !(issued >= 120 && got_q.size() >= issued); cyc++) begin
                sif.out_ready = ($urandom_range(0, 3) != 0);
                sif.in_valid  = (issued < 120) && ($urandom_range(0, 9) < 7);
                sif.in_data   = W'($urandom);
                sif.in_cnt    = CW'($urandom);
                sif.in_op     = 2'($urandom);
                #1;
                if (sif.in_valid && sif.in_ready) begin
                    r = ref_shift(32'(sif.in_data), int'(sif.in_cnt), sif.in_op, W);
                    exp_q.push_back({31'b0, (r == 32'd0), r});
                    issued++;
                end
                if (sif.out_valid && sif.out_ready)
                    got_q.push_back({31'b0, sif.out_zero, 32'(sif.out_data)});
                @(posedge clk);
                #1;
            end
            sif.in_valid = 1'b0;
            done = 1'b1;
        end
    end

    typedef struct {
        logic [15:0] d;
        logic [3:0]  c;
        logic [1:0]  op;
        logic [15:0] e;
        logic        z;
    } vec_t;

    initial begin : p_main
        vec_t        tbl [15];
        logic [15:0] od;
        logic        oz;
        int          lat;
        logic [15:0] sd [8];
        logic [3:0]  sc [8];
        logic [1:0]  so [8];
        logic [15:0] se [8];
        logic [15:0] b2b_e [3];
        int          idx;
        int          ngot;
        int          nvis;

        tbl[0]  = '{16'h8001, 4'd1,  2'b00, 16'h0003, 1'b0};
        tbl[1]  = '{16'h8000, 4'd1,  2'b01, 16'h0000, 1'b1};
        tbl[2]  = '{16'hA5A5, 4'd0,  2'b00, 16'hA5A5, 1'b0};
        tbl[3]  = '{16'hA5A5, 4'd0,  2'b01, 16'hA5A5, 1'b0};
        tbl[4]  = '{16'hA5A5, 4'd0,  2'b10, 16'hA5A5, 1'b0};
        tbl[5]  = '{16'hA5A5, 4'd0,  2'b11, 16'hA5A5, 1'b0};
        tbl[6]  = '{16'h00FF, 4'd4,  2'b01, 16'h0FF0, 1'b0};
        tbl[7]  = '{16'hF000, 4'd12, 2'b11, 16'h000F, 1'b0};
        tbl[8]  = '{16'h0001, 4'd15, 2'b10, 16'h0002, 1'b0};
        tbl[9]  = '{16'h1234, 4'd4,  2'b10, 16'h4123, 1'b0};
        tbl[10] = '{16'h1234, 4'd8,  2'b00, 16'h3412, 1'b0};
        tbl[11] = '{16'h8000, 4'd15, 2'b11, 16'h0001, 1'b0};
        tbl[12] = '{16'hFFFF, 4'd15, 2'b01, 16'h8000, 1'b0};
        tbl[13] = '{16'h0001, 4'd1,  2'b11, 16'h0000, 1'b1};
        tbl[14] = '{16'h0000, 4'd7,  2'b00, 16'h0000, 1'b1};

        dif.in_valid  = 1'b0;
        dif.in_data   = '0;
        dif.in_cnt    = '0;
        dif.in_op     = '0;
        dif.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(dif.out_valid), 64'd0);
        check("rst_out_data",  64'(dif.out_data),  64'd0);
        check("rst_out_zero",  64'(dif.out_zero),  64'd0);
        check("rst_in_ready",  64'(dif.in_ready),  64'd1);
        rst = 1'b0;
        tick();

        // Single ops: value, zero flag, latency and one-cycle output pulse.
        for (int i = 0; i < 15; i++) begin
            run_one(tbl[i].d, tbl[i].c, tbl[i].op, od, oz, lat);
            check($sformatf("vec%0d_data", i), 64'(od),  64'(tbl[i].e));
            check($sformatf("vec%0d_zero", i), 64'(oz),  64'(tbl[i].z));
            check($sformatf("vec%0d_lat", i),  64'(lat), 64'd4);
            tick();
            check($sformatf("vec%0d_pulse", i), 64'(dif.out_valid), 64'd0);
        end

        // Back-to-back issue: results on consecutive cycles starting t+4.
        b2b_e[0] = 16'h0FF0;
        b2b_e[1] = 16'h000F;
        b2b_e[2] = 16'h0002;
        dif.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dif.in_valid = 1'b1;
            dif.in_data  = tbl[6 + i].d;
            dif.in_cnt   = tbl[6 + i].c;
            dif.in_op    = tbl[6 + i].op;
            tick();
        end
        dif.in_valid = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("b2b%0d_valid", i), 64'(dif.out_valid), 64'd1);
            check($sformatf("b2b%0d_data", i),  64'(dif.out_data),  64'(b2b_e[i]));
            tick();
        end
        check("b2b_end_valid", 64'(dif.out_valid), 64'd0);

        // Stall: out_ready low for three cycles with the pipeline full.
        for (int i = 0; i < 8; i++) begin
            sd[i] = 16'($urandom);
            sc[i] = 4'($urandom);
            so[i] = 2'($urandom);
            se[i] = 16'(ref_shift(32'(sd[i]), int'(sc[i]), so[i], 16));
        end
        idx  = 0;
        ngot = 0;
        for (int c = 0; c < 60 && ngot < 8; c++) begin
            dif.out_ready = !(c >= 5 && c <= 7);
            dif.in_valid  = (idx < 8);
            if (idx < 8) begin
                dif.in_data = sd[idx];
                dif.in_cnt  = sc[idx];
                dif.in_op   = so[idx];
            end
            #1;
            if (c >= 5 && c <= 7) begin
                check($sformatf("stall%0d_valid", c),    64'(dif.out_valid), 64'd1);
                check($sformatf("stall%0d_in_ready", c), 64'(dif.in_ready),  64'd0);
                check($sformatf("stall%0d_hold", c),     64'(dif.out_data),  64'(se[1]));
            end
            if (dif.in_valid && dif.in_ready) idx++;
            if (dif.out_valid && dif.out_ready) begin
                if (ngot < 8) check($sformatf("order%0d", ngot), 64'(dif.out_data), 64'(se[ngot]));
                ngot++;
            end
            @(posedge clk);
            #1;
        end
        dif.in_valid = 1'b0;
        check("stall_count", 64'(ngot), 64'd8);
        tick();
        check("stall_drained", 64'(dif.out_valid), 64'd0);

        // Flush with three ops in flight and a fourth presented.
        dif.out_ready = 1'b1;
        nvis = 0;
        for (int c = 0; c < 14; c++) begin
            dif.in_valid = (c <= 3);
            dif.in_data  = 16'($urandom) | 16'h0001;
            dif.in_cnt   = 4'($urandom);
            dif.in_op    = 2'b00;
            flush        = (c == 3);
            #1;
            if (dif.out_valid) nvis++;
            @(posedge clk);
            #1;
        end
        flush        = 1'b0;
        dif.in_valid = 1'b0;
        check("flush_no_output", 64'(nvis), 64'd0);
        run_one(16'h1234, 4'd4, 2'b00, od, oz, lat);
        check("post_flush_data", 64'(od),  64'h2341);
        check("post_flush_lat",  64'(lat), 64'd4);
        tick();

        // Reset with a full, stalled pipeline.
        dif.out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            dif.in_valid = 1'b1;
            dif.in_data  = 16'($urandom) | 16'h0001;
            dif.in_cnt   = 4'($urandom);
            dif.in_op    = 2'b00;
            tick();
        end
        dif.in_valid = 1'b0;
        check("pre_rst_valid", 64'(dif.out_valid), 64'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_out_valid", 64'(dif.out_valid), 64'd0);
        check("mid_rst_out_data",  64'(dif.out_data),  64'd0);
        check("mid_rst_out_zero",  64'(dif.out_zero),  64'd0);
        check("mid_rst_in_ready",  64'(dif.in_ready),  64'd1);
        rst = 1'b0;
        dif.out_ready = 1'b1;
        nvis = 0;
        for (int c = 0; c < 10; c++) begin
            if (dif.out_valid) nvis++;
            tick();
        end
        check("post_rst_no_output", 64'(nvis), 64'd0);

        for (int i = 0; i < 20000 && !(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done); i++)
            @(posedge clk);
        check_sweep(3, g_sweep[0].done, g_sweep[0].exp_q, g_sweep[0].got_q);
        check_sweep(4, g_sweep[1].done, g_sweep[1].exp_q, g_sweep[1].got_q);
        check_sweep(5, g_sweep[2].done, g_sweep[2].exp_q, g_sweep[2].got_q);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
